// File: rtl/l2_to_l1_return.sv
// l2_to_l1_return: direct-mapped L2 returning 32-byte lines to L1; misses are
// filled from backing memory, and a memory that stays silent too long yields an error response.
`default_nettype none

module l2_to_l1_return #(
  parameter int LINES       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_from_l1,
  input  logic [15:0]  addr,
  output logic         busy_to_l1,
  output logic         ack_to_l1,
  output logic         err_to_l1,
  output logic [255:0] data_to_l1,
  output logic         mem_req,
  output logic [15:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [255:0] mem_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 11 - IDX_W;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOOKUP   = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [10:0]      line_q;
  logic [CNT_W-1:0] cnt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [255:0]     data_mem [LINES];
  logic [255:0]     data_q;
  logic             err_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             fill;
  logic             expired;
  logic             unused_offset;

  // Byte offset is irrelevant: every transfer is a whole line.
  assign unused_offset = ^addr[4:0];

  assign idx     = line_q[IDX_W-1:0];
  assign tag     = line_q[10:IDX_W];
  assign hit     = valid[idx] && (tag_mem[idx] == tag);
  assign fill    = (state == MEM_WAIT) && mem_ack;
  assign expired = (state == MEM_WAIT) && !mem_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req_from_l1) state_nx = LOOKUP;
      LOOKUP:   state_nx = hit ? RESP : MEM_WAIT;
      MEM_WAIT: if (mem_ack || expired) state_nx = RESP;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_to_l1 = (state != IDLE);
    ack_to_l1  = (state == RESP);
    err_to_l1  = (state == RESP) && err_q;
    mem_req    = (state == MEM_WAIT);
    mem_addr   = (state == MEM_WAIT) ? {line_q, 5'b0} : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt    <= '0;
      valid  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && req_from_l1) begin
        line_q <= addr[15:5];
      end
      cnt <= (state == MEM_WAIT) ? cnt + CNT_W'(1) : '0;
      if (fill) begin
        valid[idx] <= 1'b1;
      end
      // Response payload changes only on the transition into RESP.
      if (state == LOOKUP && hit) begin
        data_q <= data_mem[idx];
        err_q  <= 1'b0;
      end else if (fill) begin
        data_q <= mem_data;
        err_q  <= 1'b0;
      end else if (expired) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_data;
    end
  end

  assign data_to_l1 = data_q;

endmodule

`default_nettype wire
